pipeline_hazard_unit: RTL

//  Hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/ME/WB).
//  - Pre-decodes EX operand forwarding in ID and registers it into EX.
//  - Detects load-use stalls and flushes wrong-path stages on branch/jump redirect.
//  - Freezes the whole pipeline while data memory is not ready, with an optional timeout.
//  - Owns every pipeline-register enable and flush; replaces the fixed, no-hazard pipeline.

---
 rtl/pipeline_hazard_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: 5-stage MIPS hazard control (forwarding, load-use stall, redirect flush, memory freeze)
// Define HAZARD_PERF_CNT_EN to add the saturating stall/flush/wait performance counters.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int WAIT_TIMEOUT = 0
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic                  me_reg_write,
  input  logic [REG_ADDR_W-1:0] me_write_reg,
  input  logic                  me_mem_access,
  input  logic                  me_mem_ready,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic                  redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_me_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_me_flush,
  output logic                  me_wb_bubble,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      wait_cnt_total
`endif
);
  localparam int WCW = WAIT_TIMEOUT > 1 ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WCW-1:0] T_LAST = WCW'(WAIT_TIMEOUT > 0 ? WAIT_TIMEOUT - 1 : 0);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t state, state_nx;
  logic [WCW-1:0] wait_cnt;
  logic not_ready, abort, freeze, load_use, stall;
  function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] x, input logic [REG_ADDR_W-1:0] s);
    return we && x != '0 && x == s;
  endfunction
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] s);
    return hit(ex_reg_write, ex_write_reg, s) ? 2'b01 : hit(me_reg_write, me_write_reg, s) ? 2'b10 : 2'b00;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= freeze ? wait_cnt + 1'b1 : '0;
      mem_timeout <= mem_timeout | abort;
    end
  always_comb begin
    not_ready = !me_mem_ready && (state == S_WAIT || me_mem_access);
    abort     = not_ready && WAIT_TIMEOUT > 0 && wait_cnt == T_LAST;
    freeze    = not_ready && !abort;
    state_nx  = freeze ? S_WAIT : S_RUN;
  end
  // A redirect squashes the dependent instruction anyway, so it overrides the load-use stall.
  always_comb begin
    load_use     = ex_mem_read && ((id_use_rs && hit(ex_reg_write, ex_write_reg, id_rs)) ||
                                   (id_use_rt && hit(ex_reg_write, ex_write_reg, id_rt)));
    stall        = !freeze && !redirect && load_use;
    pc_en        = !freeze && !stall;
    if_id_en     = !freeze && !stall;
    id_ex_en     = !freeze;
    ex_me_en     = !freeze;
    if_id_flush  = !freeze && redirect;
    id_ex_flush  = !freeze && ((redirect && BRANCH_STAGE >= 2) || stall);
    ex_me_flush  = !freeze && redirect && BRANCH_STAGE >= 3;
    me_wb_bubble = freeze || abort;
    id_byp_a     = id_use_rs && hit(wb_reg_write, wb_write_reg, id_rs);
    id_byp_b     = id_use_rt && hit(wb_reg_write, wb_write_reg, id_rt);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (id_ex_en) begin
      fwd_a <= id_ex_flush ? 2'b00 : fwd_sel(id_rs);
      fwd_b <= id_ex_flush ? 2'b00 : fwd_sel(id_rt);
    end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt      <= '0;
      flush_cnt      <= '0;
      wait_cnt_total <= '0;
    end else begin
      stall_cnt      <= stall_cnt + CNT_W'(stall && stall_cnt != '1);
      flush_cnt      <= flush_cnt + CNT_W'(if_id_flush && flush_cnt != '1);
      wait_cnt_total <= wait_cnt_total + CNT_W'(freeze && wait_cnt_total != '1);
    end
`endif
endmodule
